// File: rtl/simple_processor_param.sv
// Parametrised multi-cycle core: program-loaded instruction memory, register
// file and ALU, sequenced by a FETCH/DECODE/EXEC/WB loop with a HALTED sink.
module simple_processor_param #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 16,
  parameter int IMEM_DEPTH = 64,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [AW-1:0]     pc,
  output logic              retire,
  output logic              zero,
  output logic              illegal,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [31:0]       ir_q;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     npc_q, npc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              retire_q, retire_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic              halted_q, halted_d;

  logic [3:0]        op, rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0] imm_ext;
  logic [AW-1:0]     imm_pc;
  logic              writes_rd;
  logic              rf_we;
  logic [DATA_W-1:0] rf_val [16];

  assign op      = ir_q[31:28];
  assign rd_idx  = ir_q[27:24];
  assign rs1_idx = ir_q[23:20];
  assign rs2_idx = ir_q[19:16];
  assign imm_pc  = ir_q[AW-1:0];

  // Narrow datapaths keep only the low bits of the immediate.
  generate
    if (DATA_W > 16) begin : g_imm_sext
      assign imm_ext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    end else begin : g_imm_trunc
      assign imm_ext = ir_q[DATA_W-1:0];
    end
  endgenerate

  assign writes_rd = (op >= OP_ADD) && (op <= OP_ADDI);
  assign rf_we     = (state_q == S_WB) && writes_rd;

  // Register file: r0 and indices beyond REG_COUNT have no storage and read 0,
  // so writes to them vanish without any extra qualification.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      if (gi == 0 || gi >= REG_COUNT) begin : g_none
        assign rf_val[gi] = '0;
      end else begin : g_reg
        logic [DATA_W-1:0] r_q, r_d;
        // Next value of this register: WB result when it is the destination.
        always_comb begin
          r_d = r_q;
          if (rf_we && rd_idx == 4'(gi)) r_d = res_q;
        end
        // Register storage, cleared by reset.
        always_ff @(posedge clk) begin
          if (reset) r_q <= '0;
          else       r_q <= r_d;
        end
        assign rf_val[gi] = r_q;
      end
    end
  endgenerate

  assign dbg_data = rf_val[dbg_sel];

  // Instruction memory: program port always writes; FETCH registers the old word.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
    if (state_q == S_FETCH) ir_q <= imem[pc_q];
  end

  // Sequencer, operand capture, ALU, branch resolution and status flags.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    retire_d  = 1'b0;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    halted_d  = halted_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        a_d     = rf_val[rs1_idx];
        b_d     = rf_val[rs2_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        npc_d = pc_q + AW'(1);
        case (op)
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_AND:  res_d = a_q & b_q;
          OP_OR:   res_d = a_q | b_q;
          OP_XOR:  res_d = a_q ^ b_q;
          OP_ADDI: res_d = a_q + imm_ext;
          OP_BEQ:  if (a_q == b_q) npc_d = pc_q + AW'(1) + imm_pc;
          OP_JMP:  npc_d = imm_pc;
          OP_HALT: npc_d = pc_q;
          default: ;
        endcase
        retire_d = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        pc_d = npc_q;
        if (writes_rd) zero_d = (res_q == '0);
        if (op >= 4'h9 && op <= 4'hE) illegal_d = 1'b1;
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // State and output registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      npc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      retire_q  <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      retire_q  <= retire_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign retire  = retire_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_simple_processor_param.sv
// Bench for simple_processor_param: table-driven programs with a retire
// scoreboard on a 32-bit core, plus hand sequences for reset and an 8-bit core.
module tb_simple_processor_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [3:0]  dbg_sel = '0;
  logic [31:0] dbg_data;
  logic [5:0]  pc;
  logic        retire, zero, illegal, halted;

  logic        reset8 = 1'b1;
  logic        prog_we8 = 1'b0;
  logic [3:0]  prog_addr8 = '0;
  logic [31:0] prog_data8 = '0;
  logic [3:0]  dbg_sel8 = '0;
  logic [7:0]  dbg_data8;
  logic [3:0]  pc8;
  logic        retire8, zero8, illegal8, halted8;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  simple_processor_param #(.DATA_W(32), .REG_COUNT(16), .IMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
    .retire(retire), .zero(zero), .illegal(illegal), .halted(halted)
  );

  simple_processor_param #(.DATA_W(8), .REG_COUNT(4), .IMEM_DEPTH(16)) dut8 (
    .clk(clk), .reset(reset8), .prog_we(prog_we8), .prog_addr(prog_addr8),
    .prog_data(prog_data8), .dbg_sel(dbg_sel8), .dbg_data(dbg_data8), .pc(pc8),
    .retire(retire8), .zero(zero8), .illegal(illegal8), .halted(halted8)
  );

  typedef struct {
    int          test;
    int          addr;
    logic [31:0] word;
  } prog_t;

  typedef struct {
    int          test;
    logic [5:0]  pc;
    logic [3:0]  rd;
    logic [31:0] val;
    logic        zero;
    logic        ill;
    logic        halt;
  } exp_t;

  prog_t prog_tbl[$];
  exp_t  exp_tbl[$];
  exp_t  sb[$];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic add_p(input int t, input int a, input logic [31:0] w);
    prog_t p;
    p.test = t; p.addr = a; p.word = w;
    prog_tbl.push_back(p);
  endtask

  task automatic add_e(input int t, input logic [5:0] p, input logic [3:0] rd,
                       input logic [31:0] v, input logic z, input logic il, input logic h);
    exp_t e;
    e.test = t; e.pc = p; e.rd = rd; e.val = v; e.zero = z; e.ill = il; e.halt = h;
    exp_tbl.push_back(e);
  endtask

  // Hold reset, fill imem with HALT, write the program of test t, check reset state.
  task automatic load_main(input int t);
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 64; a++) begin
      prog_we = 1'b1; prog_addr = 6'(a); prog_data = enc(4'hF, 0, 0, 0, 0);
      @(negedge clk);
    end
    foreach (prog_tbl[i]) begin
      if (prog_tbl[i].test == t) begin
        prog_we = 1'b1; prog_addr = 6'(prog_tbl[i].addr); prog_data = prog_tbl[i].word;
        @(negedge clk);
      end
    end
    prog_we = 1'b0;
    @(negedge clk);
    chk($sformatf("t%0d reset pc", t), 64'(pc), 0);
    chk($sformatf("t%0d reset retire", t), 64'(retire), 0);
    chk($sformatf("t%0d reset halted", t), 64'(halted), 0);
    chk($sformatf("t%0d reset illegal", t), 64'(illegal), 0);
    chk($sformatf("t%0d reset zero", t), 64'(zero), 0);
  endtask

  // Pop one expectation per retire pulse; check the architectural result the
  // following cycle. Retire n of a run must land on cycle 4n+3.
  task automatic run_sb(input int t, input int budget);
    int   cyc = 0;
    int   nret = 0;
    logic pend = 1'b0;
    exp_t cur;
    @(negedge clk);
    reset = 1'b0;
    while ((sb.size() > 0 || pend) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        dbg_sel = cur.rd;
        #1;
        chk($sformatf("t%0d r%0d value", t, cur.rd), 64'(dbg_data), 64'(cur.val));
        chk($sformatf("t%0d zero", t), 64'(zero), 64'(cur.zero));
        chk($sformatf("t%0d illegal", t), 64'(illegal), 64'(cur.ill));
        chk($sformatf("t%0d halted", t), 64'(halted), 64'(cur.halt));
        pend = 1'b0;
      end
      if (retire) begin
        if (sb.size() == 0) begin
          chk($sformatf("t%0d unexpected retire", t), 1, 0);
        end else begin
          cur = sb.pop_front();
          chk($sformatf("t%0d retire pc", t), 64'(pc), 64'(cur.pc));
          chk($sformatf("t%0d retire cycle", t), 64'(cyc), 64'(4 * nret + 3));
          $display("t%0d retire #%0d cyc=%0d pc=%0d rd=r%0d", t, nret, cyc, pc, cur.rd);
          nret++;
          pend = 1'b1;
        end
      end
    end
    if (sb.size() > 0 || pend) chk($sformatf("t%0d retire timeout", t), 0, 1);
  endtask

  task automatic push_sb(input int t);
    foreach (exp_tbl[i]) if (exp_tbl[i].test == t) sb.push_back(exp_tbl[i]);
  endtask

  initial begin
    // Test 1: straight-line arithmetic ending in HALT.
    add_p(1, 0, enc(6, 1, 0, 0, 5));
    add_p(1, 1, enc(6, 2, 0, 0, 7));
    add_p(1, 2, enc(1, 3, 1, 2, 0));
    add_p(1, 3, enc(15, 0, 0, 0, 0));
    add_e(1, 0, 1, 5, 0, 0, 0);
    add_e(1, 1, 2, 7, 0, 0, 0);
    add_e(1, 2, 3, 12, 0, 0, 0);
    add_e(1, 3, 0, 0, 0, 0, 1);
    // Test 2: subtraction wrap and zero flag.
    add_p(2, 0, enc(6, 1, 0, 0, 1));
    add_p(2, 1, enc(2, 2, 0, 1, 0));
    add_p(2, 2, enc(2, 3, 1, 1, 0));
    add_p(2, 3, enc(15, 0, 0, 0, 0));
    add_e(2, 0, 1, 1, 0, 0, 0);
    add_e(2, 1, 2, 32'hFFFF_FFFF, 0, 0, 0);
    add_e(2, 2, 3, 0, 1, 0, 0);
    add_e(2, 3, 0, 0, 1, 0, 1);
    // Test 3: taken BEQ skips 1,2; JMP to last word; NOP there wraps pc to 0.
    add_p(3, 0, enc(7, 0, 0, 0, 2));
    add_p(3, 1, enc(6, 5, 0, 0, 1));
    add_p(3, 2, enc(6, 5, 0, 0, 2));
    add_p(3, 3, enc(8, 0, 0, 0, 63));
    add_p(3, 63, enc(0, 0, 0, 0, 0));
    add_e(3, 0, 5, 0, 0, 0, 0);
    add_e(3, 3, 5, 0, 0, 0, 0);
    add_e(3, 63, 5, 0, 0, 0, 0);
    add_e(3, 0, 5, 0, 0, 0, 0);
    // Test 4: undefined opcode is a sticky-flagged NOP.
    add_p(4, 0, enc(6, 1, 0, 0, 4));
    add_p(4, 1, enc(4'hA, 1, 1, 0, 3));
    add_p(4, 2, enc(6, 2, 1, 0, 1));
    add_p(4, 3, enc(15, 0, 0, 0, 0));
    add_e(4, 0, 1, 4, 0, 0, 0);
    add_e(4, 1, 1, 4, 0, 1, 0);
    add_e(4, 2, 2, 5, 0, 1, 0);
    add_e(4, 3, 0, 0, 0, 1, 1);
    // Test 6: r0 ignores writes; negative immediate sign-extends.
    add_p(6, 0, enc(6, 0, 0, 0, 3));
    add_p(6, 1, enc(6, 4, 0, 0, 16'hFFFF));
    add_p(6, 2, enc(15, 0, 0, 0, 0));
    add_e(6, 0, 0, 0, 0, 0, 0);
    add_e(6, 1, 4, 32'hFFFF_FFFF, 0, 0, 0);
    add_e(6, 2, 0, 0, 0, 0, 1);
    // Test 5: reset during EXEC of ADDI r1,r0,9, then rerun.
    add_p(5, 0, enc(6, 1, 0, 0, 9));
    add_p(5, 1, enc(15, 0, 0, 0, 0));
    add_e(5, 0, 1, 9, 0, 0, 0);
    add_e(5, 1, 0, 0, 0, 0, 1);

    for (int t = 1; t <= 6; t++) begin
      if (t == 5) continue;
      load_main(t);
      push_sb(t);
      run_sb(t, 200);
      if (t == 1) chk("t1 final pc", 64'(pc), 3);
      if (t == 4) chk("t4 illegal sticky", 64'(illegal), 1);
    end

    // Test 5 hand sequence.
    load_main(5);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);            // two edges done: instruction is in EXEC
    reset = 1'b1;
    @(negedge clk);
    dbg_sel = 4'd1;
    #1;
    chk("t5 r1 after abort", 64'(dbg_data), 0);
    chk("t5 pc after abort", 64'(pc), 0);
    chk("t5 retire after abort", 64'(retire), 0);
    $display("t5 reset mid-EXEC r1=%0h pc=%0d", dbg_data, pc);
    push_sb(5);
    run_sb(5, 100);

    // DATA_W=8 core: immediate truncation and out-of-range register index.
    @(negedge clk);
    prog_we8 = 1'b1; prog_addr8 = 4'd0; prog_data8 = enc(6, 1, 0, 0, 16'h01FF);
    @(negedge clk);
    prog_addr8 = 4'd1; prog_data8 = enc(6, 5, 0, 0, 7);
    @(negedge clk);
    prog_addr8 = 4'd2; prog_data8 = enc(1, 2, 1, 1, 0);
    @(negedge clk);
    prog_addr8 = 4'd3; prog_data8 = enc(15, 0, 0, 0, 0);
    @(negedge clk);
    prog_we8 = 1'b0;
    @(negedge clk);
    reset8 = 1'b0;
    begin
      int n = 0;
      while (!halted8 && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("w8 halt reached", 64'(halted8), 1);
      chk("w8 halt cycle", 64'(n), 16);
    end
    chk("w8 pc", 64'(pc8), 3);
    dbg_sel8 = 4'd1; #1;
    chk("w8 r1", 64'(dbg_data8), 64'h0FF);
    dbg_sel8 = 4'd5; #1;
    chk("w8 r5 dropped", 64'(dbg_data8), 0);
    dbg_sel8 = 4'd2; #1;
    chk("w8 r2", 64'(dbg_data8), 64'h0FE);
    chk("w8 zero", 64'(zero8), 0);
    $display("w8 halted pc=%0d r2=%0h", pc8, dbg_data8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
